uart_rx: RTL and testbench

UART receiver that consumes the serial stream produced by the team's UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle-high line.
- Synchronises the asynchronous serial input, detects the start bit and samples each bit at mid-period.
- Presents each received byte on a valid/ready output interface, with framing-error and overrun status pulses.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: valid/ready data plus status pulses.
// master = receiver (drives data/status), slave = consumer (drives ready).
interface uart_rx_if;
  logic [7:0] rx_data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output rx_data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  rx_data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer and status pulses.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each bit centre.
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic     clk_i,
  input  logic     nreset_i,
  input  logic     rx_i,
  uart_rx_if.master rx_if
);

  localparam int unsigned CNT_W = 1 + $clog2(CLK_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the single-sample point; later counts inherit the shift.
  localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(CLK_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(CLK_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q,     state_d;
  logic [1:0]       sync_q,      sync_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  logic rx_s;
  logic sample_bit;
  logic commit;

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // Two previous cycles of rx_s; together with the current value they form the vote.
  assign hist_d     = {hist_q[0], rx_s};
  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign sample_bit = rx_s;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    sync_d      = {sync_q[0], rx_i};
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit      = 1'b0;

    if (valid_q && ready_i_w()) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == START_DECIDE) begin
          cnt_d   = '0;
          state_d = sample_bit ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample_bit) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A byte consumed in this same cycle frees the buffer for the new one.
    if (commit) begin
      if (!valid_q || ready_i_w()) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  function automatic logic ready_i_w();
    return rx_if.ready_i;
  endfunction

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      // NOTE: the shift register is reset too, so a fresh frame never exposes stale bits.
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data_o   = data_q;
  assign rx_if.valid_o     = valid_q;
  assign rx_if.frame_err_o = frame_err_q;
  assign rx_if.overrun_o   = overrun_q;

  a_pulses_exclusive : assert property (
    @(posedge clk_i) disable iff (!nreset_i) !(frame_err_q && overrun_q)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences and random frames
// against a frame-level reference model (queue of expected bytes and error counts).
module tb_uart_rx;

  localparam int P = 16;

  logic clk = 1'b0;
  logic nreset;
  logic rx;

  uart_rx_if rx_if ();

  uart_rx #(.CLK_PER_BIT(P)) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .rx_i     (rx),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt       = 0;
  int ov_cnt       = 0;
  int both_cnt     = 0;
  int valid_cycles = 0;
  int unstable     = 0;

  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic rand_ready  = 1'b0;
  logic ready_fixed = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_beats;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    drive(1'b0, P);
    for (int i = 0; i < 8; i++) drive(d[i], P);
    drive(stop, P);
  endtask

  // One-cycle inversion at the centre of every data bit.
  task automatic send_glitch(input logic [7:0] d);
    drive(1'b0, P);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], P / 2 - 1);
      drive(~d[i], 1);
      drive(d[i], P - P / 2);
    end
    drive(1'b1, P);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'h0, rx_if.rx_data_o}, 32'h0);
    check({tag, "_valid"}, {31'h0, rx_if.valid_o},     32'h0);
    check({tag, "_ferr"},  {31'h0, rx_if.frame_err_o}, 32'h0);
    check({tag, "_ovr"},   {31'h0, rx_if.overrun_o},   32'h0);
  endtask

  // Consumer: fixed level or random ready.
  initial begin
    rx_if.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rx_if.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (nreset) begin
      if (rx_if.valid_o && rx_if.ready_i) got_q.push_back(rx_if.rx_data_o);
      if (rx_if.valid_o) valid_cycles++;
      if (rx_if.frame_err_o) fe_cnt++;
      if (rx_if.overrun_o) ov_cnt++;
      if (rx_if.frame_err_o && rx_if.overrun_o) both_cnt++;
      if (prev_valid && !prev_hs && rx_if.valid_o && (rx_if.rx_data_o != prev_data)) unstable++;
      prev_valid = rx_if.valid_o;
      prev_hs    = rx_if.valid_o && rx_if.ready_i;
      prev_data  = rx_if.rx_data_o;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  initial begin
    int fe0, ov0, vc0, bad_cnt, gap;
    logic [7:0] d;
    logic bad;
    logic [7:0] b77;

    rx     = 1'b1;
    nreset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    nreset = 1'b1;
    drive(1'b1, 2 * P);

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h5A, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b0, 0, 1};
    vecs[6] = '{8'h7E, 1'b1, 1, 0};

    for (int v = 0; v < 7; v++) begin
      got_q.delete();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      vc0 = valid_cycles;
      send(vecs[v].data, vecs[v].stop);
      drive(1'b1, 2 * P);
      check($sformatf("vec%0d_beats", v), got_q.size(), vecs[v].exp_beats);
      if (got_q.size() > 0) check($sformatf("vec%0d_data", v), {24'h0, got_q[0]}, {24'h0, vecs[v].data});
      check($sformatf("vec%0d_ferr", v), fe_cnt - fe0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ov_cnt - ov0, 0);
      check($sformatf("vec%0d_vcyc", v), valid_cycles - vc0, vecs[v].exp_beats);
    end

    // Back-to-back frames, no idle gap.
    got_q.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drive(1'b1, 2 * P);
    check("b2b_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first",  {24'h0, got_q[0]}, 32'h00);
      check("b2b_second", {24'h0, got_q[1]}, 32'hFF);
    end

    // Short low glitch on an idle line.
    got_q.delete();
    fe0 = fe_cnt;
    drive(1'b0, 4);
    drive(1'b1, 3 * P);
    check("glitch_beats", got_q.size(), 0);
    check("glitch_ferr",  fe_cnt - fe0, 0);
    check("glitch_valid", {31'h0, rx_if.valid_o}, 0);

    // Framing error followed by a long break.
    got_q.delete();
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    drive(1'b0, 40 * P);
    drive(1'b1, 2 * P);
    check("break_ferr",  fe_cnt - fe0, 1);
    check("break_beats", got_q.size(), 0);
    send(8'h5A, 1'b1);
    drive(1'b1, 2 * P);
    check("after_break_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("after_break_data", {24'h0, got_q[0]}, 32'h5A);

    // Overrun while the consumer stalls.
    ready_fixed = 1'b0;
    drive(1'b1, P);
    got_q.delete();
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send(8'h11, 1'b1);
    drive(1'b1, P);
    send(8'h22, 1'b1);
    drive(1'b1, 2 * P);
    check("ovr_valid", {31'h0, rx_if.valid_o}, 1);
    check("ovr_data",  {24'h0, rx_if.rx_data_o}, 32'h11);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_ferr",  fe_cnt - fe0, 0);
    check("ovr_beats", got_q.size(), 0);
    ready_fixed = 1'b1;
    drive(1'b1, 4);
    check("ovr_drain_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("ovr_drain_data", {24'h0, got_q[0]}, 32'h11);
    check("ovr_drain_valid", {31'h0, rx_if.valid_o}, 0);

    // Reset during data bit 4 of 0x77.
    got_q.delete();
    b77 = 8'h77;
    drive(1'b0, P);
    for (int i = 0; i < 4; i++) drive(b77[i], P);
    drive(b77[4], P / 2);
    nreset = 1'b0;
    rx     = 1'b1;
    drive(1'b1, 3);
    check_reset_outputs("midreset");
    nreset = 1'b1;
    fe0 = fe_cnt;
    drive(1'b1, 2 * P);
    send(8'hC3, 1'b1);
    drive(1'b1, 2 * P);
    check("postreset_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("postreset_data", {24'h0, got_q[0]}, 32'hC3);
    check("postreset_ferr", fe_cnt - fe0, 0);

`ifdef UART_RX_MAJORITY_EN
    got_q.delete();
    fe0 = fe_cnt;
    send_glitch(8'h96);
    send_glitch(8'h3A);
    drive(1'b1, 2 * P);
    check("maj_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("maj_first",  {24'h0, got_q[0]}, 32'h96);
      check("maj_second", {24'h0, got_q[1]}, 32'h3A);
    end
    check("maj_ferr", fe_cnt - fe0, 0);
`endif

    // Random frames, gaps and consumer stalls against the frame-level model.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    bad_cnt = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send(d, !bad);
      if (bad) begin
        bad_cnt++;
        gap = P + $urandom_range(0, P);
      end else begin
        exp_q.push_back(d);
        gap = $urandom_range(0, 2 * P);
      end
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 3 * P);
    rand_ready = 1'b0;
    drive(1'b1, 4);
    check("rand_beats", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("rand_data%0d", i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    check("rand_ferr", fe_cnt - fe0, bad_cnt);
    check("rand_ovr",  ov_cnt - ov0, 0);

    check("pulses_exclusive", both_cnt, 0);
    check("data_stable",      unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
